// File: rtl/calc_state_norm.sv
// rtl/calc_state_norm.sv - registered state-code normaliser with accept/evaluate/lock FSM
module calc_state_norm #(
    parameter int CODE_W      = 4,
    parameter int KEY_W       = 2,
    parameter int NUM_STATES  = 10,
    parameter int RECOVER     = 0,
    parameter int ERR_CNT_W   = 8,
    parameter int LOCK_THRESH = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 key_valid,
    output logic                 key_ready,
    input  logic [KEY_W-1:0]     key,
    input  logic [1:0]           mode,
    input  logic                 clear_err,
    output logic [CODE_W-1:0]    state,
    output logic                 state_vld,
    output logic                 illegal,
    output logic                 locked,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EVAL = 2'd1,
        S_LOCK = 2'd2
    } fsm_t;

    localparam int                PART_W    = CODE_W - KEY_W;
    localparam logic [CODE_W:0]   NUM_S     = (CODE_W+1)'(NUM_STATES);
    localparam logic [CODE_W-1:0] RECOVER_C = CODE_W'(RECOVER);
    localparam logic [CODE_W-1:0] SAT_C     = CODE_W'(NUM_STATES - 1);
    localparam logic [31:0]       MOD_C     = 32'(NUM_STATES);
    localparam logic [3:0]        THRESH_C  = 4'(LOCK_THRESH);

    fsm_t                 fsm_q, fsm_d;
    logic [CODE_W-1:0]    state_q, state_d;
    logic [CODE_W-1:0]    raw_q, raw_d;
    logic [1:0]           mode_q, mode_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [3:0]           consec_q, consec_d;
    logic                 state_vld_q, state_vld_d;
    logic                 illegal_q, illegal_d;

    logic [CODE_W-1:0]    raw_in;
    logic                 raw_legal;
    logic [CODE_W-1:0]    raw_wrap;
    logic [CODE_W-1:0]    norm_code;

    assign raw_in = {state_q[PART_W-1:0], key};

    // Classify the captured raw code and pick the replacement an illegal code gets under the captured policy
    always_comb begin
        raw_legal = ({1'b0, raw_q} < NUM_S);
        raw_wrap  = CODE_W'(32'(raw_q) % MOD_C);
        norm_code = raw_q;
        if (!raw_legal) begin
            case (mode_q)
                2'd0:    norm_code = RECOVER_C;
                2'd1:    norm_code = state_q;
                2'd2:    norm_code = SAT_C;
                default: norm_code = raw_wrap;
            endcase
        end
    end

    // Next-state logic: accept in IDLE, commit and count in EVAL, hold in LOCK until cleared
    always_comb begin
        fsm_d       = fsm_q;
        state_d     = state_q;
        raw_d       = raw_q;
        mode_d      = mode_q;
        err_cnt_d   = err_cnt_q;
        consec_d    = consec_q;
        state_vld_d = 1'b0;
        illegal_d   = 1'b0;
        case (fsm_q)
            S_IDLE: begin
                if (key_valid) begin
                    raw_d  = raw_in;
                    mode_d = mode;
                    fsm_d  = S_EVAL;
                end
                if (clear_err) begin
                    err_cnt_d = '0;
                    consec_d  = '0;
                end
            end
            S_EVAL: begin
                state_d     = norm_code;
                state_vld_d = 1'b1;
                illegal_d   = !raw_legal;
                if (!raw_legal) begin
                    if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
                    consec_d = consec_q + 1'b1;
                end else begin
                    consec_d = '0;
                end
                // A clear in this cycle overrides the increment and therefore also prevents a lock
                if (clear_err) begin
                    err_cnt_d = '0;
                    consec_d  = '0;
                end
                fsm_d = (consec_d >= THRESH_C) ? S_LOCK : S_IDLE;
            end
            S_LOCK: begin
                if (clear_err) begin
                    err_cnt_d = '0;
                    consec_d  = '0;
                    fsm_d     = S_IDLE;
                end
            end
            default: fsm_d = S_IDLE;
        endcase
    end

    // State register with asynchronous reset; a reset discards any pending evaluation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q       <= S_IDLE;
            state_q     <= '0;
            raw_q       <= '0;
            mode_q      <= '0;
            err_cnt_q   <= '0;
            consec_q    <= '0;
            state_vld_q <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            state_q     <= state_d;
            raw_q       <= raw_d;
            mode_q      <= mode_d;
            err_cnt_q   <= err_cnt_d;
            consec_q    <= consec_d;
            state_vld_q <= state_vld_d;
            illegal_q   <= illegal_d;
        end
    end

    assign key_ready = (fsm_q == S_IDLE);
    assign locked    = (fsm_q == S_LOCK);
    assign state     = state_q;
    assign state_vld = state_vld_q;
    assign illegal   = illegal_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_calc_state_norm.sv
// tb/tb_calc_state_norm.sv - directed self-checking bench for calc_state_norm
module tb_calc_state_norm;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       key_valid = 1'b0;
    logic [1:0] key = 2'b00;
    logic [1:0] mode = 2'b00;
    logic       clear_err = 1'b0;

    logic       key_ready, state_vld, illegal, locked;
    logic [3:0] state;
    logic [7:0] err_cnt;

    logic       key_ready_s, state_vld_s, illegal_s, locked_s;
    logic [3:0] state_s;
    logic [1:0] err_cnt_s;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    calc_state_norm dut (
        .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_ready(key_ready),
        .key(key), .mode(mode), .clear_err(clear_err), .state(state),
        .state_vld(state_vld), .illegal(illegal), .locked(locked), .err_cnt(err_cnt)
    );

    calc_state_norm #(.ERR_CNT_W(2), .LOCK_THRESH(15)) u_sat (
        .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_ready(key_ready_s),
        .key(key), .mode(mode), .clear_err(clear_err), .state(state_s),
        .state_vld(state_vld_s), .illegal(illegal_s), .locked(locked_s), .err_cnt(err_cnt_s)
    );

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; key_valid = 1'b0; clear_err = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // offer one key in IDLE; returns #1 after the edge that commits the result
    task automatic send(input logic [1:0] k, input logic [1:0] m);
        @(negedge clk);
        key = k; mode = m; key_valid = 1'b1;
        @(posedge clk); #1;
        key_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if (state !== 4'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", state); end
        checks++; if (key_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", key_ready); end
        checks++; if (state_vld !== 1'b0) begin failures++; $display("FAIL reset_vld got=%b exp=0", state_vld); end
        checks++; if (illegal !== 1'b0) begin failures++; $display("FAIL reset_illegal got=%b exp=0", illegal); end
        checks++; if (locked !== 1'b0) begin failures++; $display("FAIL reset_locked got=%b exp=0", locked); end
        checks++; if (err_cnt !== 8'd0) begin failures++; $display("FAIL reset_err got=%0d exp=0", err_cnt); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_legal_walk();
        send(2'b01, 2'd0);
        checks++; if (state !== 4'd1) begin failures++; $display("FAIL walk1_state got=%0d exp=1", state); end
        checks++; if (state_vld !== 1'b1) begin failures++; $display("FAIL walk1_vld got=%b exp=1", state_vld); end
        checks++; if (illegal !== 1'b0) begin failures++; $display("FAIL walk1_illegal got=%b exp=0", illegal); end
        send(2'b10, 2'd0);
        checks++; if (state !== 4'd6) begin failures++; $display("FAIL walk2_state got=%0d exp=6", state); end
        checks++; if (state_vld !== 1'b1) begin failures++; $display("FAIL walk2_vld got=%b exp=1", state_vld); end
        checks++; if (illegal !== 1'b0) begin failures++; $display("FAIL walk2_illegal got=%b exp=0", illegal); end
        @(posedge clk); #1;
        checks++; if (state_vld !== 1'b0) begin failures++; $display("FAIL walk_vld_pulse got=%b exp=0", state_vld); end
    endtask

    task automatic test_illegal_modes();
        logic [3:0] exp_tab [4] = '{4'd0, 4'd3, 4'd9, 4'd5};
        for (int m = 0; m < 4; m++) begin
            do_reset();
            send(2'b11, 2'd0);
            checks++; if (state !== 4'd3) begin failures++; $display("FAIL ill_setup m=%0d got=%0d exp=3", m, state); end
            send(2'b11, 2'(m));
            checks++; if (state !== exp_tab[m]) begin failures++; $display("FAIL ill_state m=%0d got=%0d exp=%0d", m, state, exp_tab[m]); end
            checks++; if (illegal !== 1'b1) begin failures++; $display("FAIL ill_flag m=%0d got=%b exp=1", m, illegal); end
            checks++; if (err_cnt !== 8'd1) begin failures++; $display("FAIL ill_err m=%0d got=%0d exp=1", m, err_cnt); end
        end
    endtask

    task automatic test_lock();
        do_reset();
        send(2'b11, 2'd0);
        for (int i = 0; i < 3; i++) send(2'b11, 2'd1);
        checks++; if (state !== 4'd3) begin failures++; $display("FAIL lock_state got=%0d exp=3", state); end
        checks++; if (locked !== 1'b1) begin failures++; $display("FAIL lock_locked got=%b exp=1", locked); end
        checks++; if (key_ready !== 1'b0) begin failures++; $display("FAIL lock_ready got=%b exp=0", key_ready); end
        checks++; if (err_cnt !== 8'd3) begin failures++; $display("FAIL lock_err got=%0d exp=3", err_cnt); end
        @(negedge clk);
        key = 2'b00; mode = 2'd0; key_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            checks++; if (state !== 4'd3 || state_vld !== 1'b0 || locked !== 1'b1) begin
                failures++; $display("FAIL lock_hold i=%0d state=%0d vld=%b locked=%b exp 3/0/1", i, state, state_vld, locked);
            end
        end
        @(negedge clk);
        key_valid = 1'b0; clear_err = 1'b1;
        @(posedge clk); #1;
        checks++; if (locked !== 1'b0) begin failures++; $display("FAIL clear_locked got=%b exp=0", locked); end
        checks++; if (key_ready !== 1'b1) begin failures++; $display("FAIL clear_ready got=%b exp=1", key_ready); end
        checks++; if (err_cnt !== 8'd0) begin failures++; $display("FAIL clear_err got=%0d exp=0", err_cnt); end
        @(negedge clk);
        clear_err = 1'b0;
        send(2'b00, 2'd0);
        checks++; if (state !== 4'd0 || err_cnt !== 8'd1) begin
            failures++; $display("FAIL post_clear state=%0d err=%0d exp 0/1", state, err_cnt);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            send(2'b11, 2'd0);
            checks++; if (state_s !== 4'd3 || illegal_s !== 1'b0) begin
                failures++; $display("FAIL sat_legal i=%0d state=%0d ill=%b exp 3/0", i, state_s, illegal_s);
            end
            send(2'b11, 2'd0);
            checks++; if (err_cnt_s !== 2'((i + 1 > 3) ? 3 : i + 1)) begin
                failures++; $display("FAIL sat_err i=%0d got=%0d exp=%0d", i, err_cnt_s, (i + 1 > 3) ? 3 : i + 1);
            end
            checks++; if (state_s !== 4'd0 || illegal_s !== 1'b1 || locked_s !== 1'b0) begin
                failures++; $display("FAIL sat_ill i=%0d state=%0d ill=%b locked=%b exp 0/1/0", i, state_s, illegal_s, locked_s);
            end
        end
    endtask

    task automatic test_back_to_back();
        int vld_count = 0;
        do_reset();
        @(negedge clk);
        key = 2'b01; mode = 2'd0; key_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) @(negedge clk);
            checks++; if (key_ready !== ((i % 2) == 0)) begin
                failures++; $display("FAIL b2b_ready i=%0d got=%b exp=%b", i, key_ready, (i % 2) == 0);
            end
            @(posedge clk); #1;
            if (state_vld === 1'b1) vld_count++;
        end
        @(negedge clk);
        key_valid = 1'b0;
        checks++; if (vld_count !== 3) begin failures++; $display("FAIL b2b_count got=%0d exp=3", vld_count); end
        checks++; if (state !== 4'd5) begin failures++; $display("FAIL b2b_state got=%0d exp=5", state); end
    endtask

    task automatic test_async_reset();
        do_reset();
        send(2'b01, 2'd0);
        checks++; if (state !== 4'd1) begin failures++; $display("FAIL ar_setup got=%0d exp=1", state); end
        @(negedge clk);
        key = 2'b11; key_valid = 1'b1;
        @(posedge clk); #1;
        key_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (state !== 4'd0) begin failures++; $display("FAIL ar_state got=%0d exp=0", state); end
        checks++; if (key_ready !== 1'b1 || state_vld !== 1'b0) begin
            failures++; $display("FAIL ar_flags ready=%b vld=%b exp 1/0", key_ready, state_vld);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++; if (state_vld !== 1'b0 || state !== 4'd0) begin
                failures++; $display("FAIL ar_after i=%0d vld=%b state=%0d exp 0/0", i, state_vld, state);
            end
        end
    endtask

    initial begin
        test_reset();
        test_legal_walk();
        test_illegal_modes();
        test_lock();
        test_saturation();
        test_back_to_back();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1);
    end

endmodule
